// File: rtl/pwm_voltage_regulator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_voltage_regulator
// Brief    : Deadband bang-bang duty regulator with lock detect and a PWM
//            whose duty only changes at period boundaries.
//            Optional macro CVREG_SAMPLE_TIMEOUT_EN adds a stale-sample guard.
// Revision : 1.0  initial release
// ============================================================================
module pwm_voltage_regulator #(
  parameter int DATA_W        = 12,
  parameter int PWM_W         = 11,
  parameter int PWM_PERIOD    = 1241,
  parameter int MAX_DUTY      = 1116,
  parameter int REFRESH_CYCLE = 5500,
  parameter int DEADBAND_LO   = 5,
  parameter int DEADBAND_HI   = 10,
  parameter int STEP          = 1,
  parameter int LOCK_TICKS    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] set_point,
  output logic              pwm,
  output logic [PWM_W-1:0]  duty,
  output logic [1:0]        dir,
  output logic              period_start,
  output logic              at_limit,
  output logic              locked,
  output logic              stale
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_INC  = 2'b01,
    DIR_DEC  = 2'b10
  } dir_t;

  localparam int                      c_REF_W    = $clog2(REFRESH_CYCLE);
  localparam int                      c_LCK_W    = $clog2(LOCK_TICKS + 1);
  localparam logic [c_REF_W-1:0]      c_REF_LAST = c_REF_W'(REFRESH_CYCLE - 1);
  localparam logic [PWM_W-1:0]        c_CNT_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W-1:0]        c_MAX      = PWM_W'(MAX_DUTY);
  localparam logic [PWM_W:0]          c_MAX_X    = (PWM_W+1)'(MAX_DUTY);
  localparam logic [PWM_W-1:0]        c_STEP     = PWM_W'(STEP);
  localparam logic [PWM_W:0]          c_STEP_X   = (PWM_W+1)'(STEP);
  localparam logic signed [DATA_W:0]  c_DB_HI    = (DATA_W+1)'(DEADBAND_HI);
  localparam logic signed [DATA_W:0]  c_DB_LO_N  = (DATA_W+1)'(-DEADBAND_LO);
  localparam logic [c_LCK_W-1:0]      c_LCK_SAT  = c_LCK_W'(LOCK_TICKS);

  logic [DATA_W-1:0]       r_sample_q;
  logic [c_REF_W-1:0]      r_ref_cnt;
  logic                    r_tick_d;
  dir_t                    r_dir;
  logic [PWM_W-1:0]        r_duty;
  logic [PWM_W-1:0]        r_cnt;
  logic [PWM_W-1:0]        r_duty_act;
  logic                    r_pwm;
  logic                    r_period_start;
  logic [c_LCK_W-1:0]      r_idle_cnt;
  logic                    r_locked;

  logic                    w_tick;
  logic                    w_timeout;
  logic [DATA_W-1:0]       w_sample_eff;
  logic signed [DATA_W:0]  w_err;
  logic [PWM_W:0]          w_sum;
  dir_t                    w_dir_nxt;
  logic [c_LCK_W-1:0]      w_idle_nxt;
  logic                    w_locked_nxt;
  logic [PWM_W-1:0]        w_duty_nxt;

  assign w_tick       = enable & (r_ref_cnt == c_REF_LAST);
  // A sample arriving on the tick itself is used immediately.
  assign w_sample_eff = sample_valid ? sample : r_sample_q;
  assign w_err        = $signed({1'b0, set_point}) - $signed({1'b0, w_sample_eff});
  assign w_sum        = {1'b0, r_duty} + c_STEP_X;

  always_comb begin
    w_dir_nxt    = r_dir;
    w_idle_nxt   = r_idle_cnt;
    w_locked_nxt = r_locked;
    if (!enable) begin
      w_idle_nxt   = '0;
      w_locked_nxt = 1'b0;
    end else if (w_tick) begin
      if (w_timeout) begin
        w_dir_nxt    = DIR_IDLE;
        w_idle_nxt   = '0;
        w_locked_nxt = 1'b0;
      end else begin
        if (w_err > c_DB_HI)        w_dir_nxt = DIR_INC;
        else if (w_err < c_DB_LO_N) w_dir_nxt = DIR_DEC;
        else                        w_dir_nxt = DIR_IDLE;
        if (w_dir_nxt == DIR_IDLE) begin
          if (r_idle_cnt != c_LCK_SAT) w_idle_nxt = r_idle_cnt + 1'b1;
          w_locked_nxt = (w_idle_nxt == c_LCK_SAT);
        end else begin
          w_idle_nxt   = '0;
          w_locked_nxt = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_duty_nxt = r_duty;
    if (r_tick_d && enable) begin
      if (r_dir == DIR_INC)
        w_duty_nxt = (w_sum > c_MAX_X) ? c_MAX : w_sum[PWM_W-1:0];
      else if (r_dir == DIR_DEC)
        w_duty_nxt = (r_duty < c_STEP) ? '0 : (r_duty - c_STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dir      <= DIR_IDLE;
      r_idle_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_dir      <= w_dir_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sample_q     <= '0;
      r_ref_cnt      <= '0;
      r_tick_d       <= 1'b0;
      r_duty         <= '0;
      r_cnt          <= '0;
      r_duty_act     <= '0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      if (sample_valid) r_sample_q <= sample;
      if (enable)       r_ref_cnt  <= w_tick ? '0 : r_ref_cnt + 1'b1;
      r_tick_d <= w_tick;
      r_duty   <= w_duty_nxt;
      r_cnt    <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
      // Shadow load on the last count keeps each period's high time intact.
      if (r_cnt == c_CNT_LAST) r_duty_act <= r_duty;
      r_pwm          <= enable & (r_cnt < r_duty_act);
      r_period_start <= (r_cnt == '0);
    end
  end

`ifdef CVREG_SAMPLE_TIMEOUT_EN
  logic r_seen;
  logic r_stale;

  assign w_timeout = ~(r_seen | sample_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seen  <= 1'b0;
      r_stale <= 1'b0;
    end else begin
      if (w_tick)            r_seen <= 1'b0;
      else if (sample_valid) r_seen <= 1'b1;
      if (sample_valid)            r_stale <= 1'b0;
      else if (w_tick & w_timeout) r_stale <= 1'b1;
    end
  end

  assign stale = r_stale;
`else
  assign w_timeout = 1'b0;
  assign stale     = 1'b0;
`endif

  assign pwm          = r_pwm;
  assign duty         = r_duty;
  assign dir          = r_dir;
  assign period_start = r_period_start;
  assign at_limit     = (r_duty == '0) | (r_duty == c_MAX);
  assign locked       = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_pwm_voltage_regulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_voltage_regulator
// Brief    : Directed bench with a cycle-level reference model of the regulator.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_voltage_regulator;

  localparam int c_DATA_W = 12;
  localparam int c_PWM_W  = 11;
  localparam int c_PERIOD = 16;
  localparam int c_MAXD   = 12;
  localparam int c_REFR   = 8;
  localparam int c_LOCKT  = 3;
  localparam int c_DB_LO  = 5;
  localparam int c_DB_HI  = 10;
  localparam int c_STEP   = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b0;
  logic                sv  = 1'b0;
  logic [c_DATA_W-1:0] smp = '0;
  logic [c_DATA_W-1:0] sp  = '0;
  logic                pwm;
  logic [c_PWM_W-1:0]  duty;
  logic [1:0]          dir;
  logic                ps;
  logic                atl;
  logic                lck;
  logic                stl;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pwm_voltage_regulator #(
    .DATA_W(c_DATA_W), .PWM_W(c_PWM_W), .PWM_PERIOD(c_PERIOD), .MAX_DUTY(c_MAXD),
    .REFRESH_CYCLE(c_REFR), .DEADBAND_LO(c_DB_LO), .DEADBAND_HI(c_DB_HI),
    .STEP(c_STEP), .LOCK_TICKS(c_LOCKT)
  ) dut (
    .clock(clk), .reset(rst), .enable(en), .sample_valid(sv), .sample(smp),
    .set_point(sp), .pwm(pwm), .duty(duty), .dir(dir), .period_start(ps),
    .at_limit(atl), .locked(lck), .stale(stl)
  );

  // Reference model: values the outputs must hold after each clock edge.
  int m_cyc = 0, m_enc = 0, m_sq = 0, m_dir = 0, m_duty = 0, m_dact = 0, m_idle = 0;
  bit m_pend = 0, m_pwm = 0, m_ps = 0, m_lock = 0, m_seen = 0, m_stale = 0;

  always @(posedge clk) begin : model
    int cnt, s, e;
    bit tick, tmo;
    if (rst) begin
      m_cyc = 0; m_enc = 0; m_sq = 0; m_dir = 0; m_duty = 0; m_dact = 0; m_idle = 0;
      m_pend = 0; m_pwm = 0; m_ps = 0; m_lock = 0; m_seen = 0; m_stale = 0;
    end else begin
      cnt  = m_cyc % c_PERIOD;
      tick = en && ((m_enc % c_REFR) == c_REFR - 1);
`ifdef CVREG_SAMPLE_TIMEOUT_EN
      tmo = tick && !(m_seen || sv);
`else
      tmo = 1'b0;
`endif
      m_pwm = en && (cnt < m_dact);
      m_ps  = (cnt == 0);
      if (cnt == c_PERIOD - 1) m_dact = m_duty;
      m_cyc++;
      if (m_pend && en) begin
        if (m_dir == 1)      m_duty = (m_duty + c_STEP > c_MAXD) ? c_MAXD : m_duty + c_STEP;
        else if (m_dir == 2) m_duty = (m_duty - c_STEP < 0) ? 0 : m_duty - c_STEP;
      end
      if (!en) begin
        m_idle = 0; m_lock = 0;
      end else if (tick) begin
        if (tmo) begin
          m_dir = 0; m_idle = 0; m_lock = 0;
        end else begin
          s = sv ? int'(smp) : m_sq;
          e = int'(sp) - s;
          m_dir = (e > c_DB_HI) ? 1 : ((e < -c_DB_LO) ? 2 : 0);
          if (m_dir == 0) begin
            m_idle = (m_idle < c_LOCKT) ? m_idle + 1 : c_LOCKT;
            m_lock = (m_idle >= c_LOCKT);
          end else begin
            m_idle = 0; m_lock = 0;
          end
        end
      end
`ifdef CVREG_SAMPLE_TIMEOUT_EN
      if (sv) m_stale = 0; else if (tmo) m_stale = 1;
      if (tick) m_seen = 0; else if (sv) m_seen = 1;
`endif
      m_pend = tick;
      if (sv) m_sq = int'(smp);
      if (en) m_enc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pwm", int'(pwm), int'(m_pwm));
      chk("duty", int'(duty), m_duty);
      chk("dir", int'(dir), m_dir);
      chk("period_start", int'(ps), int'(m_ps));
      chk("at_limit", int'(atl), int'(m_duty == 0 || m_duty == c_MAXD));
      chk("locked", int'(lck), int'(m_lock));
      chk("stale", int'(stl), int'(m_stale));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic to_tick();
    int k = 0;
    do begin
      step(1);
      k++;
    end while (!m_pend && k < 2 * c_REFR);
    if (!m_pend) chk("tick_wait", 0, 1);
    @(negedge clk);
  endtask

  task automatic count_highs(output int hc);
    hc = 0;
    repeat (c_PERIOD) begin
      @(negedge clk);
      hc += int'(pwm);
    end
  endtask

  task automatic wait_cnt(input int c);
    int k = 0;
    while ((m_cyc % c_PERIOD) != c && k < 2 * c_PERIOD) begin
      step(1);
      k++;
    end
    if ((m_cyc % c_PERIOD) != c) chk("cnt_wait", m_cyc % c_PERIOD, c);
  endtask

  initial begin
    int hc, hc2, k;

    // Reset state
    step(3);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_at_limit", int'(atl), 1);
    chk("rst_locked", int'(lck), 0);

    // Decrement at duty 0 must not wrap
    step(1);
    rst = 1'b0; en = 1'b1; sv = 1'b1; sp = 12'd0; smp = 12'd100;
    step(40);
    @(negedge clk);
    chk("dec_dir", int'(dir), 2);
    chk("dec_duty_floor", int'(duty), 0);
    count_highs(hc);
    chk("dec_pwm_highs", hc, 0);

    // Increment to saturation
    sp = 12'd1000; smp = 12'd900;
    step(130);
    @(negedge clk);
    chk("inc_dir", int'(dir), 1);
    chk("inc_duty_sat", int'(duty), 12);
    chk("inc_at_limit", int'(atl), 1);
    count_highs(hc);
    chk("inc_pwm_highs", hc, 12);

    // Deadband edges (err = 5, -5, 10) lock; err = 11 breaks lock
    smp = 12'd995;  to_tick();
    chk("db1_dir", int'(dir), 0);
    smp = 12'd1005; to_tick();
    chk("db2_unlocked", int'(lck), 0);
    smp = 12'd990;  to_tick();
    chk("db3_locked", int'(lck), 1);
    chk("db3_dir", int'(dir), 0);
    smp = 12'd989;  to_tick();
    chk("unlock_dir", int'(dir), 1);
    chk("unlock_locked", int'(lck), 0);

    // Place ticks at cnt 3 and 11 so duty changes land at cnt 5 and 13
    smp = 12'd1000;
    en = 1'b0;
    k = 0;
    while ((((m_cyc % c_PERIOD) + (c_REFR - 1) - (m_enc % c_REFR)) % c_REFR) != 3 && k < 2 * c_PERIOD) begin
      step(1);
      k++;
    end
    en = 1'b1;
    step(32);
    wait_cnt(0);
    smp = 12'd1100;
    @(negedge clk);
    count_highs(hc);
    count_highs(hc2);
    chk("midchange_cur_period", hc, 12);
    chk("midchange_next_period", hc2, 10);

    // Reset in mid-period with duty 8
    smp = 12'd1000;
    wait_cnt(6);
    @(negedge clk);
    chk("pre_rst_duty", int'(duty), 8);
    chk("pre_rst_pwm", int'(pwm), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pwm", int'(pwm), 0);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_dir", int'(dir), 0);
    chk("midrst_at_limit", int'(atl), 1);

    // Sample arriving on the tick cycle is used for that tick
    sv = 1'b1; smp = 12'd1000;
    step(2);
    sv = 1'b0; smp = 12'd900;
    k = 0;
    while ((m_enc % c_REFR) != c_REFR - 1 && k < 2 * c_REFR) begin
      step(1);
      k++;
    end
    sv = 1'b1;
    step(1);
    sv = 1'b1; smp = 12'd1000;
    @(negedge clk);
    chk("bypass_dir", int'(dir), 1);

    // Withheld samples across refresh windows
    step(20);
    sv = 1'b0;
    step(20);
    @(negedge clk);
`ifdef CVREG_SAMPLE_TIMEOUT_EN
    chk("timeout_stale", int'(stl), 1);
`else
    chk("timeout_stale", int'(stl), 0);
`endif
    chk("timeout_dir", int'(dir), 0);
    chk("timeout_duty", int'(duty), 1);
    sv = 1'b1;
    step(1);
    @(negedge clk);
    chk("resume_stale", int'(stl), 0);

    step(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
